muxn_pipe: RTL and testbench
============================

Name: muxn_pipe

Overview:
- Parametrised N-input, WIDTH-bit select stage for datapath operand and writeback selection.
- Output is registered, with a valid/ready handshake and a 2-entry skid buffer, so a select can sit on a stall-able pipeline boundary.
- Out-of-range selects yield zero data and are flagged and counted.
- Supersedes the fixed 2/3/4-input 32-bit combinational selectors wherever a registered select is needed.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 4, number of data inputs; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2^SEL_W >= NUM_IN.
- CNT_W, 8, width of the saturating out-of-range counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  synchronous pipeline flush; drops all held entries.
- in_data  input  NUM_IN*WIDTH  flattened inputs; input i occupies bits [i*WIDTH +: WIDTH].
- in_sel  input  SEL_W  binary select, sampled with in_valid.
- in_valid  input  1  upstream offers in_data/in_sel.
- in_ready  output  1  stage can accept this cycle.
- out_data  output  WIDTH  selected word, registered.
- out_oob  output  1  held word came from an out-of-range select.
- out_valid  output  1  out_data/out_oob valid.
- out_ready  input  1  downstream accepts this cycle.
- err_cnt  output  CNT_W  count of accepted out-of-range selects, saturating.

Behaviour:
- Reset:
  - Clock is single; reset is synchronous and active-high.
  - While rst is high at a rising edge: out_valid=0, out_data=0, out_oob=0, skid empty, err_cnt=0.
  - in_ready=0 combinationally while rst is high.
- Select function (combinational, internal):
  - If in_sel < NUM_IN: word = input[in_sel], oob = 0.
  - Otherwise: word = 0, oob = 1.
- Accept/deliver:
  - Accept = in_valid & in_ready.
  - Deliver = out_valid & out_ready.
- in_ready = !skid_valid & !rst. It is registered-state only; there is no combinational path from out_ready to in_ready.
- Storage: main register (drives outputs) plus one skid register, each holding {data, oob, valid}.
- Next-state rules when not in reset or flush:
  - Main empty, accept: main <= selected word; out_valid=1 after the edge (latency 1 cycle).
  - Main full, deliver, skid full: main <= skid; skid empties. No accept is possible, since in_ready=0.
  - Main full, deliver, skid empty, accept: main <= new word.
  - Main full, deliver, skid empty, no accept: main empties.
  - Main full, no deliver, accept: skid <= new word; in_ready drops next cycle.
  - Main full, no deliver, no accept: hold all state. out_data/out_oob stay stable while out_valid=1 and out_ready=0.
- Ordering: strict FIFO; no word is duplicated or lost except by flush.
- Throughput: 1 word/cycle sustained when out_ready is held high.
- Flush (rst has priority over flush):
  - Next edge: out_valid=0 and skid empty.
  - A word accepted in the same cycle is discarded.
  - out_data is not cleared.
  - err_cnt is unchanged by flush.
- err_cnt:
  - Increments on every accept with oob=1, including accepts discarded by a simultaneous flush.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by rst.
- Illegal parameterisation (NUM_IN > 2^SEL_W or NUM_IN < 2) must fail at elaboration.

Test Plan:
1. Reset, then in_sel=2, in_data inputs {0x33,0x22,0x11,0x00} (input 2 = 0x22), in_valid=1, out_ready=1 -> out_valid=1 and out_data=0x22 one cycle later; in_ready stays 1.
2. NUM_IN=3, SEL_W=2, in_sel=3 accepted -> out_data=0, out_oob=1, err_cnt=1. Then 300 back-to-back out-of-range accepts with CNT_W=8 -> err_cnt=255 and holds.
3. Backpressure: out_ready=0; accept word A (sel 0) then B (sel 1) -> in_ready=0 from the cycle after B; out_data=A stable. Raise out_ready -> A then B delivered on consecutive cycles; in_ready returns to 1.
4. Streaming: 16 words with in_sel cycling 0..3 and out_ready=1 -> 16 outputs in order, 1 per cycle, latency 1.
5. Flush with main and skid full plus simultaneous accept -> out_valid=0 and in_ready=1 next cycle; none of the three words is delivered.
6. Assert rst mid-stream with skid full and err_cnt=5 -> after the edge out_valid=0, out_data=0, err_cnt=0; in_ready=0 during rst and 1 after rst deasserts.

Source files
------------

// File: rtl/muxn_pipe.sv
// Registered N-input select stage with a valid/ready handshake and a 2-entry skid buffer.
// Out-of-range selects produce zero data, are flagged with the word, and are counted.
module muxn_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_oob,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        err_cnt
);

  if (NUM_IN < 2 || NUM_IN > (1 << SEL_W)) begin : gen_bad_param
    $error("muxn_pipe: NUM_IN must lie in 2..2**SEL_W");
  end

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [WIDTH-1:0] sel_word;
  logic             sel_oob;

  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             main_oob_q, main_oob_d;
  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_oob_q, skid_oob_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic accept;
  logic deliver;

  // Any select value not matching a real input falls through to zero data with oob set.
  always_comb begin
    sel_word = '0;
    sel_oob  = 1'b1;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (in_sel == SEL_W'(i)) begin
        sel_word = in_data[i*WIDTH +: WIDTH];
        sel_oob  = 1'b0;
      end
    end
  end

  // Ready depends on registered state only, never on out_ready.
  assign in_ready = !skid_valid_q && !rst;
  assign accept   = in_valid && in_ready;
  assign deliver  = main_valid_q && out_ready;

  always_comb begin
    main_data_d  = main_data_q;
    main_oob_d   = main_oob_q;
    main_valid_d = main_valid_q;
    skid_data_d  = skid_data_q;
    skid_oob_d   = skid_oob_q;
    skid_valid_d = skid_valid_q;

    if (flush) begin
      // Held words and any same-cycle accept are dropped; out_data keeps its last value.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      if (accept) begin
        main_data_d  = sel_word;
        main_oob_d   = sel_oob;
        main_valid_d = 1'b1;
      end
    end else if (deliver) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        main_oob_d   = skid_oob_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_data_d = sel_word;
        main_oob_d  = sel_oob;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_data_d  = sel_word;
      skid_oob_d   = sel_oob;
      skid_valid_d = 1'b1;
    end
  end

  // Counts oob accepts even when a flush discards them.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && sel_oob && (err_cnt_q != CntMax)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_data_q  <= '0;
      main_oob_q   <= 1'b0;
      main_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_oob_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      main_data_q  <= main_data_d;
      main_oob_q   <= main_oob_d;
      main_valid_q <= main_valid_d;
      skid_data_q  <= skid_data_d;
      skid_oob_q   <= skid_oob_d;
      skid_valid_q <= skid_valid_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign out_data  = main_data_q;
  assign out_oob   = main_oob_q;
  assign out_valid = main_valid_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_muxn_pipe.sv
// Bench for muxn_pipe: directed scenarios plus random traffic, checked every cycle against
// a depth-2 FIFO model with a saturating error count.
module tb_muxn_pipe;
  localparam int W = 32;
  localparam int N = 3;
  localparam int S = 2;
  localparam int C = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic [N*W-1:0] in_data;
  logic [S-1:0]   in_sel;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   out_data;
  logic           out_oob;
  logic           out_valid;
  logic           out_ready;
  logic [C-1:0]   err_cnt;

  muxn_pipe #(
    .WIDTH (W),
    .NUM_IN(N),
    .SEL_W (S),
    .CNT_W (C)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_oob  (out_oob),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: words held by the stage, oldest first, plus the error count.
  logic [W-1:0] m_data[$];
  logic         m_oob[$];
  int           m_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic [W-1:0] d;
    logic         o;
    bit           acc;
    bit           dlv;
    int           s;
    if (rst) begin
      m_data.delete();
      m_oob.delete();
      m_err = 0;
    end else begin
      s = int'(in_sel);
      if (s < N) begin
        d = in_data[s*W +: W];
        o = 1'b0;
      end else begin
        d = '0;
        o = 1'b1;
      end
      acc = in_valid && (m_data.size() < 2);
      dlv = (m_data.size() > 0) && out_ready;
      if (acc && o && m_err < (1 << C) - 1) m_err++;
      if (flush) begin
        m_data.delete();
        m_oob.delete();
      end else begin
        if (dlv) begin
          void'(m_data.pop_front());
          void'(m_oob.pop_front());
        end
        if (acc) begin
          m_data.push_back(d);
          m_oob.push_back(o);
        end
      end
    end
  endtask

  task automatic compare();
    chk("in_ready", 32'(in_ready), 32'(!rst && m_data.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(m_data.size() > 0));
    chk("err_cnt", 32'(err_cnt), 32'(m_err));
    if (m_data.size() > 0) begin
      chk("out_data", out_data, m_data[0]);
      chk("out_oob", 32'(out_oob), 32'(m_oob[0]));
    end
  endtask

  // Check at the falling edge, advance the model at the rising edge, return just after it.
  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    logic [W-1:0] first_exp;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    @(posedge clk);
    model_step();
    #1;
    step();
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("reset err_cnt", 32'(err_cnt), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;

    // Basic select: input 2 is 0x22
    in_data   = {32'h22, 32'h11, 32'h00};
    in_sel    = 2'd2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    chk("t1 out_valid", 32'(out_valid), 32'd1);
    chk("t1 out_data", out_data, 32'h22);
    chk("t1 in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    step();

    // Out-of-range select and counter saturation
    in_sel   = 2'd3;
    in_valid = 1'b1;
    step();
    chk("t2 out_data", out_data, 32'd0);
    chk("t2 out_oob", 32'(out_oob), 32'd1);
    chk("t2 err_cnt", 32'(err_cnt), 32'd1);
    for (int i = 0; i < 300; i++) step();
    chk("t2 err_cnt sat", 32'(err_cnt), 32'd255);
    in_valid = 1'b0;
    step();
    step();
    chk("t2 err_cnt hold", 32'(err_cnt), 32'd255);

    // Backpressure into the skid buffer
    in_data   = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    step();
    in_sel = 2'd1;
    step();
    chk("t3 in_ready", 32'(in_ready), 32'd0);
    chk("t3 out_data A", out_data, 32'hAAAA_0000);
    in_valid = 1'b0;
    step();
    step();
    chk("t3 out_data stable", out_data, 32'hAAAA_0000);
    chk("t3 out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    chk("t3 out_data B", out_data, 32'hBBBB_0001);
    chk("t3 in_ready back", 32'(in_ready), 32'd1);
    step();
    chk("t3 drained", 32'(out_valid), 32'd0);

    // Streaming at full rate
    out_ready = 1'b1;
    in_valid  = 1'b1;
    first_exp = '0;
    for (int i = 0; i < 16; i++) begin
      in_sel  = S'(i % 4);
      in_data = {$urandom, $urandom, $urandom};
      if (i == 0) first_exp = in_data[W-1:0];
      step();
      if (i == 0) begin
        chk("t4 first valid", 32'(out_valid), 32'd1);
        chk("t4 first data", out_data, first_exp);
      end
    end
    in_valid = 1'b0;
    step();

    // Flush with main and skid full while upstream still offers
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    step();
    in_sel = 2'd1;
    step();
    in_sel = 2'd2;
    flush  = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t5 out_valid", 32'(out_valid), 32'd0);
    chk("t5 in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    step();
    step();
    chk("t5 nothing delivered", 32'(out_valid), 32'd0);

    // Reset mid-stream with skid full and err_cnt at 5
    rst = 1'b1;
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sel    = 2'd3;
    for (int i = 0; i < 5; i++) step();
    chk("t6 err_cnt 5", 32'(err_cnt), 32'd5);
    out_ready = 1'b0;
    in_sel    = 2'd0;
    step();
    in_sel = 2'd1;
    step();
    chk("t6 skid full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("t6 in_ready in rst", 32'(in_ready), 32'd0);
    step();
    chk("t6 out_valid", 32'(out_valid), 32'd0);
    chk("t6 out_data", out_data, 32'd0);
    chk("t6 err_cnt", 32'(err_cnt), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("t6 in_ready after", 32'(in_ready), 32'd1);

    // A flushed out-of-range accept still counts
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sel    = 2'd3;
    flush     = 1'b1;
    step();
    chk("flush oob err_cnt", 32'(err_cnt), 32'd1);
    chk("flush oob out_valid", 32'(out_valid), 32'd0);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_sel    = S'($urandom_range(0, 3));
      in_data   = {$urandom, $urandom, $urandom};
      flush     = ($urandom_range(0, 24) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
